// File: rtl/wb_ram_resp_if.sv
// Wishbone classic bus bundle between an initiator and the wb_ram_resp responder.
// Signal names keep the responder's point of view (_i into the RAM, _o out of it).
interface wb_ram_resp_if #(
    parameter int AW = 32
);
    logic [AW-1:0] wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_sel_i,
        input  wb_we_i,
        input  wb_cyc_i,
        input  wb_stb_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o
    );

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_sel_i,
        output wb_we_i,
        output wb_cyc_i,
        output wb_stb_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o
    );
endinterface

// File: rtl/wb_ram_resp.sv
// Wishbone classic RAM responder: byte-lane writes, WAIT wait states, error on
// out-of-range addresses, exactly one registered ack/err pulse per request.
module wb_ram_resp #(
    parameter int AW    = 32,
    parameter int DEPTH = 256,
    parameter int WAIT  = 1
) (
    input  logic         wb_clk,
    input  logic         wb_rst_n,
    wb_ram_resp_if.slave wb
);

    localparam int         IW        = $clog2(DEPTH);
    localparam logic [3:0] WCNT_INIT = 4'((WAIT > 0) ? (WAIT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TERM
    } state_e;

    state_e        state_q;
    logic [3:0]    wcnt_q;
    logic          ack_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [IW-1:0] idx_q;
    logic [31:0]   wdat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          oor_q;

    logic [31:0]   mem_q [DEPTH];

    logic          cs;
    logic [IW-1:0] idx_in;
    logic          oor_in;
    logic          adr_lsb_unused;

    logic [IW-1:0] idx_d;
    logic          oor_d;
    logic          we_d;
    logic          term_go;

    assign cs             = wb.wb_cyc_i & wb.wb_stb_i;
    assign idx_in         = wb.wb_adr_i[IW+1:2];
    assign adr_lsb_unused = ^wb.wb_adr_i[1:0];

    if (AW > IW + 2) begin : g_range
        assign oor_in = |wb.wb_adr_i[AW-1:IW+2];
    end else begin : g_norange
        assign oor_in = 1'b0;
    end

    // With WAIT=0 termination is decided in IDLE, straight from the bus inputs.
    always_comb begin
        idx_d = idx_q;
        oor_d = oor_q;
        we_d  = we_q;
        if (state_q == S_IDLE) begin
            idx_d = idx_in;
            oor_d = oor_in;
            we_d  = wb.wb_we_i;
        end
    end

    assign term_go = cs & (((state_q == S_IDLE) && (WAIT == 0)) ||
                           ((state_q == S_WAIT) && (wcnt_q == 4'd0)));

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (term_go) begin
                ack_q <= ~oor_d;
                err_q <= oor_d;
                if (!oor_d && !we_d) begin
                    rdata_q <= mem_q[idx_d];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (cs) begin
                        if (WAIT == 0) begin
                            state_q <= S_TERM;
                        end else begin
                            state_q <= S_WAIT;
                            wcnt_q  <= WCNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Dropping cs mid-wait abandons the request silently.
                    if (!cs) begin
                        state_q <= S_IDLE;
                        wcnt_q  <= 4'd0;
                    end else if (wcnt_q == 4'd0) begin
                        state_q <= S_TERM;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                S_TERM: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Request fields are captured once, at the sampling edge, and held to termination.
    always_ff @(posedge wb_clk) begin
        if ((state_q == S_IDLE) && cs) begin
            idx_q  <= idx_in;
            wdat_q <= wb.wb_dat_i;
            sel_q  <= wb.wb_sel_i;
            we_q   <= wb.wb_we_i;
            oor_q  <= oor_in;
        end
    end

    always_ff @(posedge wb_clk) begin
        if ((state_q == S_TERM) && we_q && !oor_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign wb.wb_dat_o = rdata_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;

endmodule

// File: tb/tb_wb_ram_resp.sv
// Bench for wb_ram_resp: four responders (WAIT 0,1,3,5) share one bus and are
// compared each cycle against a request-timeline model, plus directed literal checks.
module tb_wb_ram_resp;

    localparam int AW    = 32;
    localparam int DEPTH = 256;
    localparam int ND    = 4;
    localparam int NH    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;

    logic          d_ack [ND];
    logic          d_err [ND];
    logic [31:0]   d_dat [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 5;
        wb_ram_resp_if #(.AW(AW)) bus ();
        assign bus.wb_adr_i = adr;
        assign bus.wb_dat_i = dat;
        assign bus.wb_sel_i = sel;
        assign bus.wb_we_i  = we;
        assign bus.wb_cyc_i = cyc;
        assign bus.wb_stb_i = stb;
        assign d_ack[g]     = bus.wb_ack_o;
        assign d_err[g]     = bus.wb_err_o;
        assign d_dat[g]     = bus.wb_dat_o;
        wb_ram_resp #(.AW(AW), .DEPTH(DEPTH), .WAIT(W)) dut (
            .wb_clk  (clk),
            .wb_rst_n(rst_n),
            .wb      (bus)
        );
    end

    function automatic int wv(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 5;
        endcase
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Behavioural model: each responder owns at most one request, identified by
    // the edge index t0 at which it was sampled.
    logic [31:0]   mm    [ND][DEPTH];
    bit            act   [ND];
    int            t0    [ND];
    logic [AW-1:0] r_adr [ND];
    logic [31:0]   r_dat [ND];
    logic [3:0]    r_sel [ND];
    bit            r_we  [ND];
    bit            e_ack [ND];
    bit            e_err [ND];
    logic [31:0]   e_dat [ND];
    int            ecnt   = 0;
    bit            chk_en = 1'b0;

    function automatic bit out_of_range(input logic [AW-1:0] a);
        return (a / (DEPTH * 4)) != 0;
    endfunction

    function automatic int word_of(input logic [AW-1:0] a);
        return int'((a % (DEPTH * 4)) / 4);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < ND; k++) begin
            act[k]   = 1'b0;
            e_ack[k] = 1'b0;
            e_err[k] = 1'b0;
            e_dat[k] = 32'd0;
        end
    endfunction

    function automatic void model_term(input int k);
        if (out_of_range(r_adr[k])) begin
            e_err[k] = 1'b1;
        end else begin
            e_ack[k] = 1'b1;
            if (!r_we[k]) e_dat[k] = mm[k][word_of(r_adr[k])];
        end
    endfunction

    function automatic void model_write(input int k);
        logic [31:0] mask;
        int          w;
        mask = 32'd0;
        for (int b = 0; b < 4; b++) if (r_sel[k][b]) mask = mask | (32'hFF << (8 * b));
        w = word_of(r_adr[k]);
        mm[k][w] = (mm[k][w] & ~mask) | (r_dat[k] & mask);
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            ecnt++;
            for (int k = 0; k < ND; k++) begin
                e_ack[k] = 1'b0;
                e_err[k] = 1'b0;
                if (act[k]) begin
                    if (ecnt == t0[k] + wv(k) + 1) begin
                        if (r_we[k] && !out_of_range(r_adr[k])) model_write(k);
                        act[k] = 1'b0;
                    end else if (!(cyc && stb)) begin
                        act[k] = 1'b0;
                    end else if (ecnt == t0[k] + wv(k)) begin
                        model_term(k);
                    end
                end else if (cyc && stb) begin
                    r_adr[k] = adr;
                    r_dat[k] = dat;
                    r_sel[k] = sel;
                    r_we[k]  = we;
                    t0[k]    = ecnt;
                    act[k]   = 1'b1;
                    if (wv(k) == 0) model_term(k);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < ND; k++) begin
                chk($sformatf("ack_w%0d", wv(k)), 32'(d_ack[k]), 32'(e_ack[k]));
                chk($sformatf("err_w%0d", wv(k)), 32'(d_err[k]), 32'(e_err[k]));
                chk($sformatf("dat_w%0d", wv(k)), d_dat[k], e_dat[k]);
            end
        end
    end

    // Per-edge snapshots for the directed literal checks.
    logic        h_ack [ND][NH];
    logic        h_err [ND][NH];
    logic [31:0] h_dat [ND][NH];
    logic [31:0] init_val [DEPTH];

    task automatic tick(input int e);
        @(posedge clk);
        @(negedge clk);
        if (e >= 0 && e < NH) begin
            for (int k = 0; k < ND; k++) begin
                h_ack[k][e] = d_ack[k];
                h_err[k][e] = d_err[k];
                h_dat[k][e] = d_dat[k];
            end
        end
    endtask

    // cs held for 'hold' edges, then cyc alone drops for one gap edge.
    task automatic req(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, input int hold);
        adr = a;
        dat = d;
        sel = s;
        we  = w;
        cyc = 1'b1;
        stb = 1'b1;
        for (int e = 0; e < hold; e++) tick(e);
        cyc = 1'b0;
        tick(hold);
        stb = 1'b0;
    endtask

    int n;

    initial begin
        rst_n = 1'b1;
        adr   = '0;
        dat   = '0;
        sel   = '0;
        we    = 1'b0;
        cyc   = 1'b0;
        stb   = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            chk("reset_ack", 32'(d_ack[k]), 32'd0);
            chk("reset_err", 32'(d_err[k]), 32'd0);
            chk("reset_dat", d_dat[k], 32'd0);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            init_val[i] = $urandom;
            req(32'(i * 4), init_val[i], 4'hF, 1'b1, 7);
        end

        // Basic write then read, WAIT=1 timing pinned.
        req(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 7);
        chk("w1_wr_ack_e0", 32'(h_ack[1][0]), 32'd0);
        chk("w1_wr_ack_e1", 32'(h_ack[1][1]), 32'd1);
        req(32'h10, 32'h0, 4'hF, 1'b0, 7);
        chk("w1_rd_ack", 32'(h_ack[1][1]), 32'd1);
        chk("w1_rd_err", 32'(h_err[1][1]), 32'd0);
        chk("w1_rd_dat", h_dat[1][1], 32'hDEADBEEF);
        for (int k = 0; k < ND; k++) chk("rd_dat_all", h_dat[k][wv(k)], 32'hDEADBEEF);

        // Byte lanes.
        req(32'h14, 32'h11223344, 4'hF, 1'b1, 7);
        req(32'h14, 32'hAABBCCDD, 4'b0101, 1'b1, 7);
        req(32'h14, 32'h0, 4'hF, 1'b0, 7);
        for (int k = 0; k < ND; k++) chk("lane_dat", h_dat[k][wv(k)], 32'h11BB33DD);

        // Out of range read and write.
        req(32'h400, 32'h0, 4'hF, 1'b0, 7);
        n = 0;
        for (int e = 0; e < 8; e++) n += int'(h_err[3][e]);
        chk("oor_rd_err_cnt_w5", 32'(n), 32'd1);
        for (int k = 0; k < ND; k++) begin
            chk("oor_rd_err", 32'(h_err[k][wv(k)]), 32'd1);
            chk("oor_rd_ack", 32'(h_ack[k][wv(k)]), 32'd0);
            chk("oor_rd_dat", h_dat[k][wv(k)], 32'h11BB33DD);
        end
        req(32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 7);
        chk("oor_wr_err_w5", 32'(h_err[3][5]), 32'd1);
        chk("oor_wr_ack_w5", 32'(h_ack[3][5]), 32'd0);
        req(32'h0, 32'h0, 4'hF, 1'b0, 7);
        for (int k = 0; k < ND; k++) chk("oor_word0", h_dat[k][wv(k)], init_val[0]);

        // Abort: cyc dropped after one cycle.
        req(32'h20, 32'h5555AAAA, 4'hF, 1'b1, 2);
        n = 0;
        for (int e = 0; e < 3; e++) n += int'(h_ack[2][e]) + int'(h_err[2][e]);
        chk("abort_term_w3", 32'(n), 32'd0);
        req(32'h20, 32'h0, 4'hF, 1'b0, 7);
        chk("abort_dat_w3", h_dat[2][3], init_val[8]);
        chk("abort_dat_w5", h_dat[3][5], init_val[8]);
        chk("abort_dat_w0", h_dat[0][0], 32'h5555AAAA);

        // Back-to-back reads on WAIT=0 with cs held.
        we  = 1'b0;
        sel = 4'hF;
        adr = 32'h0;
        cyc = 1'b1;
        stb = 1'b1;
        tick(0);
        tick(1);
        adr = 32'h4;
        tick(2);
        tick(3);
        adr = 32'h8;
        tick(4);
        tick(5);
        cyc = 1'b0;
        stb = 1'b0;
        tick(6);
        for (int e = 0; e < 6; e++) chk($sformatf("b2b_ack_e%0d", e), 32'(h_ack[0][e]), 32'((e % 2) == 0));
        chk("b2b_dat0", h_dat[0][0], init_val[0]);
        chk("b2b_dat1", h_dat[0][2], init_val[1]);
        chk("b2b_dat2", h_dat[0][4], init_val[2]);
        repeat (2) tick(-1);

        // Reset in the middle of a request.
        adr = 32'h30;
        dat = 32'h0BADF00D;
        sel = 4'hF;
        we  = 1'b1;
        cyc = 1'b1;
        stb = 1'b1;
        tick(0);
        tick(1);
        tick(2);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < ND; k++) begin
            chk("rstmid_ack", 32'(d_ack[k]), 32'd0);
            chk("rstmid_err", 32'(d_err[k]), 32'd0);
            chk("rstmid_dat", d_dat[k], 32'd0);
        end
        cyc = 1'b0;
        stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) tick(e);
        n = 0;
        for (int e = 0; e < 8; e++) n += int'(h_ack[3][e]) + int'(h_err[3][e]);
        chk("rstmid_noterm_w5", 32'(n), 32'd0);
        req(32'h30, 32'h0, 4'hF, 1'b0, 7);
        chk("rstmid_dat_w5", h_dat[3][5], init_val[12]);
        chk("rstmid_dat_w3", h_dat[2][3], init_val[12]);
        chk("rstmid_dat_w0", h_dat[0][0], 32'h0BADF00D);

        // Randomized traffic over a few words plus occasional out-of-range addresses.
        repeat (2000) begin
            if ($urandom_range(0, 1) == 1) begin
                adr = 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) adr = adr | (32'd1 << $urandom_range(10, 31));
                dat = $urandom;
                sel = 4'($urandom_range(0, 15));
                we  = 1'($urandom_range(0, 1));
            end
            cyc = ($urandom_range(0, 9) != 0);
            stb = ($urandom_range(0, 7) != 0);
            tick(-1);
        end
        cyc = 1'b0;
        stb = 1'b0;
        repeat (10) tick(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
